// File: rtl/ejector_if.sv
// Channel-side and local-side signals of the ejector, bundled for port connection.
// The slave modport is the ejector; the master modport is whoever drives the channels and the core.
interface ejector_if;
    logic [9:0] eastad;
    logic [9:0] westad;
    logic [9:0] northad;
    logic [9:0] southad;
    logic [9:0] ead;
    logic [9:0] wad;
    logic [9:0] nad;
    logic [9:0] sad;
    logic [9:0] local_data;
    logic       local_valid;
    logic       local_ready;
    logic [7:0] stall_cnt;

    modport slave (
        input  eastad, westad, northad, southad, local_ready,
        output ead, wad, nad, sad, local_data, local_valid, stall_cnt
    );

    modport master (
        output eastad, westad, northad, southad, local_ready,
        input  ead, wad, nad, sad, local_data, local_valid, stall_cnt
    );
endinterface

// File: rtl/ejector.sv
// Network node ejector: removes at most one flit per cycle addressed to this node into a
// 4-entry buffer (round-robin over channels) and forwards every other flit after one register stage.
module ejector #(
    parameter logic [2:0] LOCAL_ROW  = 3'd4,
    parameter logic [2:0] LOCAL_COL  = 3'd4,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    ejector_if.slave bus
);

    localparam logic [2:0] FULL_CNT = 3'(FIFO_DEPTH);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic is_local(input logic [9:0] f);
        return f[9] && (f[5:3] == LOCAL_ROW) && (f[2:0] == LOCAL_COL);
    endfunction

    logic [9:0] in_flit [4];
    logic [9:0] out_d   [4];
    logic [9:0] out_q   [4];
    logic [9:0] mem_q   [4];
    logic [3:0] hit;
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    logic       eject;
    logic       do_read;
    logic [9:0] wr_data;
    logic [1:0] ptr_d, ptr_q;
    logic [1:0] wr_ptr_d, wr_ptr_q;
    logic [1:0] rd_ptr_d, rd_ptr_q;
    logic [2:0] count_d, count_q;
    logic [7:0] stall_d, stall_q;

    assign in_flit[0] = bus.eastad;
    assign in_flit[1] = bus.westad;
    assign in_flit[2] = bus.northad;
    assign in_flit[3] = bus.southad;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hit[i] = is_local(in_flit[i]);
        end
    end

    // Round-robin search starting at ptr; first local-destined channel wins.
    always_comb begin
        idx   = '0;
        sel   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && hit[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Full test uses the pre-edge count, so a same-cycle read never frees a slot.
    assign eject   = found && (count_q < FULL_CNT);
    assign do_read = (count_q != 3'd0) && bus.local_ready;
    assign wr_data = in_flit[sel];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            out_d[i] = (eject && (sel == 2'(i))) ? 10'b0 : in_flit[i];
        end
        ptr_d    = eject ? sel + 2'd1 : ptr_q;
        wr_ptr_d = eject ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = do_read ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d  = count_q + 3'(eject) - 3'(do_read);
        stall_d  = ((|hit) && (count_q == FULL_CNT)) ? sat_inc8(stall_q) : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                out_q[i] <= 10'b0;
            end
            ptr_q    <= 2'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            stall_q  <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                out_q[i] <= out_d[i];
            end
            ptr_q    <= ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Buffer storage needs no reset: it is only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (eject) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign bus.ead         = out_q[0];
    assign bus.wad         = out_q[1];
    assign bus.nad         = out_q[2];
    assign bus.sad         = out_q[3];
    assign bus.local_valid = (count_q != 3'd0);
    assign bus.local_data  = (count_q != 3'd0) ? mem_q[rd_ptr_q] : 10'b0;
    assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_ejector.sv
// Directed bench for the ejector: a vector table for single-edge behaviour plus
// hand sequences for FIFO fill/drain, stall saturation and asynchronous reset.
module tb_ejector;

    typedef struct packed {
        logic [9:0] e, w, n, s;
        logic       rdy;
        logic [9:0] xe, xw, xn, xs;
        logic       xv;
        logic [9:0] xd;
        logic [7:0] xst;
    } vec_t;

    localparam logic [9:0] P  = 10'h2A3;
    localparam logic [9:0] LA = 10'h224;
    localparam logic [9:0] LB = 10'h264;
    localparam logic [9:0] LC = 10'h2A4;
    localparam logic [9:0] LD = 10'h2E4;
    localparam logic [9:0] LE = 10'h324;
    localparam logic [9:0] LF = 10'h364;
    localparam logic [9:0] LG = 10'h3A4;
    localparam int NV = 13;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    vec_t vecs [NV];

    ejector_if bus ();

    ejector #(.LOCAL_ROW(3'd4), .LOCAL_COL(3'd4), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [9:0] e, w, n, s, input logic rdy);
        bus.eastad      = e;
        bus.westad      = w;
        bus.northad     = n;
        bus.southad     = s;
        bus.local_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ead"}, bus.ead, 10'h0);
        chk({tag, " wad"}, bus.wad, 10'h0);
        chk({tag, " nad"}, bus.nad, 10'h0);
        chk({tag, " sad"}, bus.sad, 10'h0);
        chk({tag, " valid"}, 10'(bus.local_valid), 10'h0);
        chk({tag, " data"}, bus.local_data, 10'h0);
        chk({tag, " stall"}, 10'(bus.stall_cnt), 10'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //          e   w   n   s  rdy  xe  xw  xn  xs  xv  xd  xst
        vecs[0]  = '{P,  0,  0,  0,  0,  P,  0,  0,  0,  0,  0,  0};
        vecs[1]  = '{LA, LA, LA, LA, 1,  0,  LA, LA, LA, 1,  LA, 0};
        vecs[2]  = '{LA, LA, LA, LA, 1,  LA, 0,  LA, LA, 1,  LA, 0};
        vecs[3]  = '{LA, LA, LA, LA, 1,  LA, LA, 0,  LA, 1,  LA, 0};
        vecs[4]  = '{LA, LA, LA, LA, 1,  LA, LA, LA, 0,  1,  LA, 0};
        vecs[5]  = '{0,  0,  0,  0,  1,  0,  0,  0,  0,  0,  0,  0};
        vecs[6]  = '{0,  0,  LA, 0,  0,  0,  0,  0,  0,  1,  LA, 0};
        vecs[7]  = '{0,  LB, 0,  0,  0,  0,  0,  0,  0,  1,  LA, 0};
        vecs[8]  = '{0,  0,  0,  LC, 1,  0,  0,  0,  0,  1,  LB, 0};
        vecs[9]  = '{0,  0,  0,  0,  1,  0,  0,  0,  0,  1,  LC, 0};
        vecs[10] = '{0,  0,  0,  0,  1,  0,  0,  0,  0,  0,  0,  0};
        vecs[11] = '{LD, LB, 0,  0,  0,  0,  LB, 0,  0,  1,  LD, 0};
        vecs[12] = '{0,  0,  0,  0,  1,  0,  0,  0,  0,  0,  0,  0};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk_all_zero("post-release idle");

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].e, vecs[i].w, vecs[i].n, vecs[i].s, vecs[i].rdy);
            step();
            chk($sformatf("v%0d ead", i), bus.ead, vecs[i].xe);
            chk($sformatf("v%0d wad", i), bus.wad, vecs[i].xw);
            chk($sformatf("v%0d nad", i), bus.nad, vecs[i].xn);
            chk($sformatf("v%0d sad", i), bus.sad, vecs[i].xs);
            chk($sformatf("v%0d valid", i), 10'(bus.local_valid), 10'(vecs[i].xv));
            chk($sformatf("v%0d data", i), bus.local_data, vecs[i].xd);
            chk($sformatf("v%0d stall", i), 10'(bus.stall_cnt), 10'(vecs[i].xst));
        end

        // Fill with the core stalled: four ejected, two deflected and counted as stalls.
        begin
            logic [9:0] fill [6];
            logic [9:0] exp_e [6];
            logic [7:0] exp_st [6];
            fill   = '{LA, LB, LC, LD, LE, LF};
            exp_e  = '{10'h0, 10'h0, 10'h0, 10'h0, LE, LF};
            exp_st = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
            for (int i = 0; i < 6; i++) begin
                drive(fill[i], 0, 0, 0, 0);
                step();
                chk($sformatf("fill%0d ead", i), bus.ead, exp_e[i]);
                chk($sformatf("fill%0d data", i), bus.local_data, LA);
                chk($sformatf("fill%0d stall", i), 10'(bus.stall_cnt), 10'(exp_st[i]));
            end
        end

        // Full plus read in the same cycle: no write, the new flit is deflected.
        drive(LG, 0, 0, 0, 1);
        step();
        chk("full-rw ead", bus.ead, LG);
        chk("full-rw stall", 10'(bus.stall_cnt), 10'd3);
        chk("full-rw data", bus.local_data, LB);

        drive(0, 0, 0, 0, 1);
        step();
        chk("drain1 data", bus.local_data, LC);
        step();
        chk("drain2 data", bus.local_data, LD);
        step();
        chk("drain3 valid", 10'(bus.local_valid), 10'h0);
        chk("drain3 data", bus.local_data, 10'h0);

        // Refill, then hold the FIFO full under local traffic until the stall counter saturates.
        drive(LA, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step();
        chk("refill stall", 10'(bus.stall_cnt), 10'd3);
        drive(LA, P, 0, 0, 0);
        for (int i = 0; i < 260; i++) step();
        chk("sat stall", 10'(bus.stall_cnt), 10'hFF);
        chk("sat ead", bus.ead, LA);
        chk("sat wad", bus.wad, P);

        drive(0, P, 0, 0, 1);
        step();
        chk("pre-reset valid", 10'(bus.local_valid), 10'h1);
        chk("pre-reset data", bus.local_data, LA);
        chk("pre-reset wad", bus.wad, P);
        chk("pre-reset stall", 10'(bus.stall_cnt), 10'hFF);

        // Asynchronous reset away from any clock edge.
        drive(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        #2;
        rst_n = 1'b1;
        #1;
        chk_all_zero("released before edge");

        drive(LA, LA, LA, LA, 0);
        step();
        chk("after-reset ead", bus.ead, 10'h0);
        chk("after-reset wad", bus.wad, LA);
        chk("after-reset nad", bus.nad, LA);
        chk("after-reset sad", bus.sad, LA);
        chk("after-reset valid", 10'(bus.local_valid), 10'h1);
        chk("after-reset data", bus.local_data, LA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
